// File: rtl/instruction_fetch_unit_if.sv
// Bus-0 memory port, execute redirect and decode handshake of the instruction fetch unit.
// The master modport is the fetch unit; the slave modport is the memory/decode/execute side.
interface instruction_fetch_unit_if #(
  parameter int N = 32
);
  logic [N-1:0] mem_addr;
  logic         mem_wr_ena;
  logic [N-1:0] mem_din;
  logic [N-1:0] mem_rdata;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_instr;
  logic [N-1:0] out_pc;
  logic         out_fault;

  modport master (
    output mem_addr, mem_wr_ena, mem_din,
    input  mem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc, out_fault,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_wr_ena, mem_din,
    output mem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc, out_fault,
    output out_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: pc, one-cycle memory latency tracking, 2-entry instruction buffer, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky out_fault instead of being aligned.
module instruction_fetch_unit #(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = 32'h4000_0000
) (
  input  logic clk,
  input  logic rstb,
  instruction_fetch_unit_if.master bus
);
  localparam int DEPTH = 2;

  logic [N-1:0] pc_reg;
  logic         inflight_reg;
  logic [N-1:0] inflight_pc_reg;
  logic [1:0]   occ_reg;
  logic         head_reg;
  logic         tail_reg;

  logic [N-1:0] entry_pc    [DEPTH];
  logic [N-1:0] entry_instr [DEPTH];

  logic         redirect;
  logic         pop;
  logic         push;
  logic         issue;
  logic         fault;
  logic [2:0]   demand;
  logic [N-1:0] redirect_target;

  assign redirect = bus.redirect_valid;
  assign pop      = (occ_reg != 2'd0) & bus.out_ready & ~redirect;
  assign push     = inflight_reg & ~redirect;
  // Words already owed to the buffer after this cycle's pop; issuing is safe only below 2.
  assign demand   = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue    = ~redirect & ~fault & (demand < 3'd2);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_reg;

  assign redirect_target = bus.redirect_pc;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      fault_reg <= 1'b0;
    end else if (redirect) begin
      fault_reg <= |bus.redirect_pc[1:0];
    end
  end

  assign fault = fault_reg;
`else
  assign redirect_target = bus.redirect_pc & {{(N-2){1'b1}}, 2'b00};
  assign fault           = 1'b0;
`endif

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      occ_reg         <= 2'd0;
      head_reg        <= 1'b0;
      tail_reg        <= 1'b0;
    end else if (redirect) begin
      // The word returning this cycle belongs to the old stream and is dropped.
      pc_reg       <= redirect_target;
      inflight_reg <= 1'b0;
      occ_reg      <= 2'd0;
      head_reg     <= 1'b0;
      tail_reg     <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= pc_reg;
        pc_reg          <= pc_reg + N'(4);
      end
      if (push) begin
        tail_reg <= ~tail_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [N-1:0] pc_q;
    logic [N-1:0] instr_q;

    always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
        pc_q    <= '0;
        instr_q <= '0;
      end else if (push && (tail_reg == 1'(gi))) begin
        pc_q    <= inflight_pc_reg;
        instr_q <= bus.mem_rdata;
      end
    end

    assign entry_pc[gi]    = pc_q;
    assign entry_instr[gi] = instr_q;
  end

  assign bus.mem_addr   = pc_reg;
  assign bus.mem_wr_ena = 1'b0;
  assign bus.mem_din    = '0;

  assign bus.out_valid = (occ_reg != 2'd0) & ~redirect;
  assign bus.out_instr = entry_instr[head_reg];
  assign bus.out_pc    = entry_pc[head_reg];
  assign bus.out_fault = fault;
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end fetch stage that sits directly upstream of the shared dual-port memory's bus 0. It holds the program counter, drives the bus-0 read address every cycle and tracks the memory's one-cycle registered read latency. Returned instruction words go into a 2-entry buffer and are presented to decode with a valid/ready handshake. Redirects from execute (branches, jumps) flush all in-flight and buffered words.

## Interface
- N, 32, data/address width
- RESET_PC, 32'h4000_0000, first fetch address after reset (start of the instruction address space)
- clk  in  1  clock, all state on rising edge
- rstb  in  1  reset, asynchronous, active-high (rstb=1 resets)
- mem_addr  out  N  bus-0 address; equals the pc register; the memory samples it every edge
- mem_wr_ena  out  1  bus-0 write enable, constant 0
- mem_din  out  N  bus-0 write data, constant 0
- mem_rdata  in  N  bus-0 read data; valid the cycle after the edge that sampled mem_addr
- redirect_valid  in  1  load a new fetch target this cycle
- redirect_pc  in  N  new fetch target
- out_valid  out  1  out_instr/out_pc hold a fetched word
- out_ready  in  1  decode accepts; transfer when out_valid & out_ready
- out_instr  out  N  instruction word
- out_pc  out  N  address out_instr was fetched from
- out_fault  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: pc (N), inflight (1) plus inflight_pc (N), 2-entry FIFO of {pc, instr}, occ (0..2).
- Reset values: pc=RESET_PC, inflight=0, occ=0, out_valid=0, out_instr=0, out_pc=0, out_fault=0.
- pop = out_valid & out_ready & ~redirect_valid.
- issue = ~redirect_valid & ~out_fault & (occ + inflight - pop < 2).
- On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4 (mod 2^N, 32'hFFFF_FFFC wraps to 0). If no issue: inflight<=0 and pc holds. mem_addr still shows pc, and the memory's next-cycle data is discarded.
- When inflight=1, mem_rdata is valid this cycle: push {inflight_pc, mem_rdata} into the FIFO.
- Push and pop in the same cycle is legal. The issue rule guarantees a push never overflows.
- out_valid = (occ != 0) & ~redirect_valid. out_instr and out_pc come from the FIFO head.
- Redirect has priority over everything:
  - pc <= redirect_pc (alignment handling per Configuration)
  - inflight<=0, occ<=0
  - no transfer occurs in the redirect cycle even if out_ready=1
  - the word arriving on mem_rdata that cycle is dropped
- Reset asserted mid-operation: all state returns to reset values immediately. Words in flight are lost.

## Timing
- Reset released before edge E0: mem_addr=RESET_PC during cycle 1. Data arrives in cycle 2 and is pushed at the end of cycle 2. out_valid=1 in cycle 3.
- Redirect in cycle t: mem_addr=target in t+1; out_valid with out_pc=target in t+3.
- Throughput: one word per cycle sustained while out_ready=1.
- out_ready low: at most one more issue occurs, then issue stops with occ=2, inflight=0. No word is lost or duplicated.
- out_ready rising again: transfer in the same cycle. Issue resumes that cycle, so the next-but-one word follows without a bubble gap larger than 1.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - a redirect with redirect_pc[1:0]!=0 sets out_fault=1 on the next edge and loads pc with redirect_pc unmodified
  - while out_fault=1 there is no issue, and out_valid stays 0 once the FIFO is flushed
  - an aligned redirect clears out_fault and resumes fetching
- Not defined: pc <= {redirect_pc[N-1:2],2'b00}, and out_fault is tied 0.

## Test plan
- Reset release, out_ready=1, memory preloaded with word k = 32'h1000_0000+k → out_valid first in cycle 3 with out_pc=32'h4000_0000, out_instr=32'h1000_0000, then one word per cycle with out_pc incrementing by 4.
- out_ready held 0 for 5 cycles after the first word, then 1 → occ reaches 2, pc stops advancing, and the output sequence resumes without gaps or duplicates (0x4000_0000, 0x4000_0004, 0x4000_0008, ...).
- redirect_valid with redirect_pc=32'h4000_0100 while occ=2 and inflight=1 → out_valid=0 for cycles t..t+2, then out_pc=32'h4000_0100. No older word appears after the redirect.
- Redirect in the same cycle as out_ready=1 and out_valid pending → no transfer counted, and the FIFO is flushed.
- RESET_PC=32'hFFFF_FFF8 → out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- redirect_pc=32'h4000_0102:
  - FETCH_MISALIGN_TRAP_EN defined: out_fault=1, no further out_valid, then an aligned redirect to 32'h4000_0000 clears out_fault and resumes fetching.
  - Not defined: out_pc=32'h4000_0100.
